// File: rtl/quad_pkg.sv
// Shared quadrature-decoder definitions: state encodings, filter length limits, default counter width.
// No logic and no latency of its own.
package quad_pkg;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S10 = 2'b10;

    localparam int FILTER_LEN_MIN = 2;
    localparam int FILTER_LEN_MAX = 15;
    localparam int CNT_W_DEF      = 16;

    // Successor of a {a,b} state in the forward rotation 00->01->11->10->00.
    function automatic logic [1:0] fwd_next(input logic [1:0] s);
        case (s)
            S00:     return S01;
            S01:     return S11;
            S11:     return S10;
            default: return S00;
        endcase
    endfunction

endpackage

// File: rtl/glitch_filter.sv
// One encoder channel: 2-flop synchronizer, then a run-length glitch filter.
// Filtered level moves FILTER_LEN+2 edges after a stable raw change; no backpressure.
module glitch_filter
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic cclk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    localparam int RUN_W = $clog2(FILTER_LEN_MAX + 1);

    logic             sync1;
    logic             sync2;
    logic [RUN_W-1:0] run;

    always_ff @(posedge cclk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            run   <= '0;
            filt  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // The run never exceeds FILTER_LEN-1: reaching FILTER_LEN commits the level and restarts.
            if (sync2 == filt) begin
                run <= '0;
            end else if (run == RUN_W'(FILTER_LEN - 1)) begin
                filt <= sync2;
                run  <= '0;
            end else begin
                run <= run + RUN_W'(1);
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B -> step/dir/err pulses and a wrapping signed position count.
// step/err arrive FILTER_LEN+3 edges after a stable raw change; no backpressure. QUAD_X4_EN selects x4 (else x1).
module quad_decoder
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             cclk,
    input  logic             rst,
    input  logic             a_raw,
    input  logic             b_raw,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic [CNT_W-1:0] count
);

    if (FILTER_LEN < FILTER_LEN_MIN || FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_len
        $error("quad_decoder: FILTER_LEN out of range");
    end

    // Without a change, the state 00 is trusted as the starting point once the
    // filters have had time to confirm it.
    localparam int PRIME_CYC = 2 * FILTER_LEN + 2;

    logic       a_f;
    logic       b_f;
    logic [1:0] cur;
    logic [1:0] prev;
    logic       primed;
    logic [5:0] prime_cnt;
    logic       chg;
    logic       illegal;
    logic       fwd;
    logic       rev;
    logic       cnt_fwd;
    logic       cnt_rev;

    glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .cclk (cclk),
        .rst  (rst),
        .raw  (a_raw),
        .filt (a_f)
    );

    glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .cclk (cclk),
        .rst  (rst),
        .raw  (b_raw),
        .filt (b_f)
    );

    assign cur = {a_f, b_f};

    always_comb begin
        chg     = (cur != prev);
        illegal = ((cur ^ prev) == 2'b11);
        fwd     = (cur == fwd_next(prev));
        rev     = (prev == fwd_next(cur));
`ifdef QUAD_X4_EN
        cnt_fwd = fwd;
        cnt_rev = rev;
`else
        cnt_fwd = fwd && (prev == S00);
        cnt_rev = rev && (prev == S01);
`endif
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            step      <= 1'b0;
            err       <= 1'b0;
            dir       <= 1'b0;
            count     <= '0;
            prev      <= S00;
            primed    <= 1'b0;
            prime_cnt <= '0;
        end else begin
            step <= 1'b0;
            err  <= 1'b0;
            if (!primed) begin
                if (chg) begin
                    prev   <= cur;
                    primed <= 1'b1;
                end else if (prime_cnt == 6'(PRIME_CYC - 1)) begin
                    primed <= 1'b1;
                end else begin
                    prime_cnt <= prime_cnt + 6'd1;
                end
            end else if (chg) begin
                prev <= cur;
                if (illegal) begin
                    err <= 1'b1;
                end else if (cnt_fwd) begin
                    step  <= 1'b1;
                    dir   <= 1'b1;
                    count <= count + CNT_W'(1);
                end else if (cnt_rev) begin
                    step  <= 1'b1;
                    dir   <= 1'b0;
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (FILTER_LEN=4, CNT_W=4); expectations follow QUAD_X4_EN.
module tb_quad_decoder;
    import quad_pkg::*;

    localparam int FL = 4;
    localparam int CW = 4;
`ifdef QUAD_X4_EN
    localparam int X4 = 1;
`else
    localparam int X4 = 0;
`endif

    logic          cclk  = 1'b0;
    logic          rst   = 1'b1;
    logic          a_raw = 1'b0;
    logic          b_raw = 1'b0;
    logic          step;
    logic          dir;
    logic          err;
    logic [CW-1:0] count;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [CW-1:0] exp_count = '0;
    logic          exp_dir   = 1'b0;
    logic [1:0]    cur_s     = S00;

    quad_decoder #(.FILTER_LEN(FL), .CNT_W(CW)) u_dut (
        .cclk  (cclk),
        .rst   (rst),
        .a_raw (a_raw),
        .b_raw (b_raw),
        .step  (step),
        .dir   (dir),
        .err   (err),
        .count (count)
    );

    always #5 cclk = ~cclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] rev_next(input logic [1:0] s);
        return fwd_next(fwd_next(fwd_next(s)));
    endfunction

    // Called at a negedge; holds state s for 10 cycles and checks the pulse pattern.
    task automatic drv(input logic [1:0] s, input int exp_step, input logic step_dir,
                       input int exp_err, input string tag);
        int ns = 0;
        int ne = 0;
        int ps = 0;
        int pe = 0;
        a_raw = s[1];
        b_raw = s[0];
        for (int k = 1; k <= 10; k++) begin
            @(negedge cclk);
            if (step === 1'b1) begin ns++; ps = k; end
            if (err === 1'b1) begin ne++; pe = k; end
        end
        chk({tag, "_steps"}, ns, exp_step);
        chk({tag, "_errs"}, ne, exp_err);
        if (exp_step != 0) begin
            chk({tag, "_step_lat"}, ps, FL + 3);
            exp_dir   = step_dir;
            exp_count = step_dir ? exp_count + 4'd1 : exp_count - 4'd1;
        end
        if (exp_err != 0) chk({tag, "_err_lat"}, pe, FL + 3);
        chk({tag, "_count"}, count, exp_count);
        chk({tag, "_dir"}, dir, exp_dir);
        cur_s = s;
    endtask

    task automatic do_reset(input logic [1:0] s, input string tag);
        a_raw = s[1];
        b_raw = s[0];
        rst   = 1'b1;
        repeat (3) @(negedge cclk);
        chk({tag, "_step"}, step, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_dir"}, dir, 0);
        chk({tag, "_count"}, count, 0);
        rst       = 1'b0;
        exp_count = '0;
        exp_dir   = 1'b0;
        cur_s     = s;
    endtask

    initial begin
        int         gs;
        int         ge;
        bit         done;
        logic [1:0] s_mid;

        // Power-up onto 11: the prime absorbs the first filtered state.
        do_reset(S11, "rst11");
        drv(S11, 0, 1'b0, 0, "prime11a");
        drv(S11, 0, 1'b0, 0, "prime11b");

        do_reset(S00, "rst00");
        drv(S00, 0, 1'b0, 0, "idle_a");
        drv(S00, 0, 1'b0, 0, "idle_b");

        drv(S01, 1,  1'b1, 0, "f01");
        drv(S11, X4, 1'b1, 0, "f11");
        drv(S10, X4, 1'b1, 0, "f10");
        drv(S00, X4, 1'b1, 0, "f00");
        chk("fwd_total", count, (X4 != 0) ? 4 : 1);

        // 3-cycle glitch on A is shorter than the filter.
        gs = 0;
        ge = 0;
        a_raw = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge cclk);
            if (k == 2) a_raw = 1'b0;
            if (step === 1'b1) gs++;
            if (err === 1'b1) ge++;
        end
        chk("glitch_steps", gs, 0);
        chk("glitch_errs", ge, 0);
        chk("glitch_count", count, (X4 != 0) ? 4 : 1);

        drv(S11, 0,  1'b1, 1, "ill00_11");
        drv(S10, X4, 1'b1, 0, "i10");
        drv(S00, X4, 1'b1, 0, "i00");

        drv(S10, X4, 1'b0, 0, "r10");
        drv(S11, X4, 1'b0, 0, "r11");
        drv(S01, X4, 1'b0, 0, "r01");
        drv(S00, 1,  1'b0, 0, "r00");
        chk("rev_total", count, (X4 != 0) ? 2 : 0);
        chk("rev_dir", dir, 0);

        // Wrap at CNT_W=4: +7 -> -8 -> +7.
        for (int i = 0; i < 40 && exp_count != 4'd7; i++)
            drv(fwd_next(cur_s), (X4 != 0 || cur_s == S00) ? 1 : 0, 1'b1, 0, "wrap_up");
        chk("at_max", count, 7);
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            done = (X4 != 0 || cur_s == S00);
            drv(fwd_next(cur_s), done ? 1 : 0, 1'b1, 0, "wrap_fwd");
        end
        chk("wrap_neg", count, 8);
        drv(rev_next(cur_s), 1, 1'b0, 0, "wrap_rev");
        chk("wrap_back", count, 7);

        // Reset during a partially filtered transition.
        s_mid = fwd_next(cur_s);
        a_raw = s_mid[1];
        b_raw = s_mid[0];
        repeat (4) @(negedge cclk);
        rst = 1'b1;
        @(negedge cclk);
        chk("midrst_step", step, 0);
        chk("midrst_err", err, 0);
        chk("midrst_dir", dir, 0);
        chk("midrst_count", count, 0);
        repeat (2) @(negedge cclk);
        rst       = 1'b0;
        exp_count = '0;
        exp_dir   = 1'b0;
        drv(s_mid, 0, 1'b0, 0, "post_a");
        drv(s_mid, 0, 1'b0, 0, "post_b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
